cache_controller: RTL
=====================

Name: cache_controller

Overview:
Sequencing controller for the 4-line direct-mapped 1024-bit-line cache. It accepts byte read/write requests from the CPU side over a req/ack handshake and owns the tag/valid/dirty store and the line array. It resolves hits locally, handles misses with write-back of dirty victims and line refill over a line-wide memory handshake, and supports a whole-cache flush.

Parameters:
LINE_BITS, 1024, line width in bits (128 bytes)
NUM_LINES, 4, number of lines; index width IDX_W = log2(NUM_LINES) = 2
ADDR_W, 32, byte address width; offset 7 bits [6:0], index [8:7], tag [31:9] (23 bits)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
cpu_req  in  1  request strobe; sampled only in IDLE
cpu_we  in  1  1 = byte write, 0 = byte read
cpu_addr  in  32  byte address
cpu_wdata  in  8  write byte
cpu_rdata  out  8  read byte; valid with cpu_ack, held until next ack
cpu_ack  out  1  one-cycle completion pulse
busy  out  1  high whenever state != IDLE
hit  out  1  one-cycle pulse on a LOOKUP hit (first lookup of a request only)
miss  out  1  one-cycle pulse on a LOOKUP miss
flush_req  in  1  write back all dirty lines, then invalidate all; sampled only in IDLE
flush_done  out  1  one-cycle pulse at flush completion
mem_req  out  1  memory transaction request; held until mem_ready
mem_we  out  1  1 = line write-back, 0 = line fetch
mem_addr  out  32  line-aligned address (offset bits zero)
mem_wdata  out  1024  victim line for write-back
mem_rdata  in  1024  fetched line; valid when mem_ready high during fetch
mem_ready  in  1  transaction completes on the rising edge where mem_req && mem_ready

Behaviour:
- Reset (async, immediate): state = IDLE; all valid/dirty bits = 0; tags = 0; cpu_rdata = 0; cpu_ack, hit, miss, flush_done, mem_req, mem_we = 0; mem_addr and mem_wdata = 0. Line data is not reset. Reset mid-transaction abandons it; no ack is issued.
- All outputs are registered.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND, FLUSH_SCAN, FLUSH_WB.
- IDLE: if flush_req, latch nothing and go to FLUSH_SCAN with line counter = 0. Else if cpu_req, capture addr/we/wdata and go to LOOKUP. flush_req has priority when both are high.
- LOOKUP: hit = valid[idx] && tag[idx] == captured tag.
  - On hit: read loads cpu_rdata with byte[offset]; write updates that byte and sets dirty[idx]; go to RESPOND.
  - On miss with valid && dirty: go to WRITEBACK.
  - On any other miss: go to REFILL.
- hit/miss pulse on the first LOOKUP of a request only; the post-refill re-lookup pulses neither.
- WRITEBACK: mem_req = 1, mem_we = 1, mem_addr = {old tag, idx, 7'b0}, mem_wdata = line. On the mem_ready edge, drop mem_req and go to REFILL.
- REFILL: mem_req = 1, mem_we = 0, mem_addr = {new tag, idx, 7'b0}. On the mem_ready edge, line = mem_rdata, tag = new tag, valid = 1, dirty = 0, then go to LOOKUP (which guarantees a hit).
- RESPOND: cpu_ack = 1 for exactly this cycle, then go to IDLE.
- Hit latency: cpu_req sampled at edge N, ack high in the cycle after edge N+2.
- Back-to-back: cpu_req may be high in the ack cycle, but it is not accepted until the next IDLE cycle. Requesters hold cpu_req until ack.
- mem_req and mem_addr/mem_wdata stay stable while waiting. An unbounded mem_ready wait is legal. mem_ready while mem_req = 0 is ignored.
- FLUSH_SCAN: if valid[cnt] && dirty[cnt], go to FLUSH_WB. Otherwise clear valid[cnt] and increment cnt. When cnt reaches NUM_LINES-1 and that line is done, pulse flush_done and go to IDLE.
- FLUSH_WB: write back line cnt (as in WRITEBACK). On mem_ready, clear dirty/valid[cnt] and return to FLUSH_SCAN at cnt+1, or finish if cnt was the last line.
- Counter cnt is IDX_W bits; its wrap after the last line is never used.

Test Plan:
1. Reset, then read 0x0000_0205 → miss pulse; REFILL mem_addr = 0x0000_0200, mem_we = 0. Return mem_rdata byte5 = 0xA5 with mem_ready after 3 cycles → cpu_ack, cpu_rdata = 0xA5; no hit pulse.
2. Repeat read 0x0000_0205 → hit pulse; ack exactly 2 cycles after acceptance; no mem_req.
3. Write 0x3C to 0x0000_0206 (hit), then read 0x0000_1206 (same idx 0, different tag) → WRITEBACK first: mem_addr = 0x0000_0200, mem_wdata byte6 = 0x3C. Then REFILL at 0x0000_1200.
4. Dirty lines at idx 1 and 3, clean line at idx 0, assert flush_req with cpu_req → exactly two write-backs, in order idx 1 then 3. flush_done pulses once, cpu_req is then serviced as a miss.
5. Assert rst during a REFILL wait → mem_req drops immediately, no ack. Next read of that address misses.
6. Hold mem_ready low for 20 cycles during WRITEBACK → mem_req, mem_addr, mem_wdata stable; busy = 1 throughout.

Source files
------------

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 4-line direct-mapped cache sequencer with write-back, refill and flush
module cache_controller #(
    parameter int LINE_BITS = 1024,
    parameter int NUM_LINES = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [7:0]           cpu_wdata,
    output logic [7:0]           cpu_rdata,
    output logic                 cpu_ack,
    output logic                 busy,
    output logic                 hit,
    output logic                 miss,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ready
);
    localparam int OFF_W = $clog2(LINE_BITS / 8);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND, FLUSH_SCAN, FLUSH_WB
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   we_q, we_d;
    logic [7:0]             wdata_q, wdata_d;
    logic                   first_q, first_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]       tag_q [NUM_LINES];
    logic [TAG_W-1:0]       tag_d [NUM_LINES];
    logic [7:0]             rdata_q, rdata_d;
    logic                   ack_q, ack_d, hit_q, hit_d, miss_q, miss_d, fdone_q, fdone_d;
    logic                   mreq_q, mreq_d, mwe_q, mwe_d;
    logic [ADDR_W-1:0]      maddr_q, maddr_d;
    logic [LINE_BITS-1:0]   mwdata_q, mwdata_d;

    logic [LINE_BITS-1:0]   line_mem [NUM_LINES];
    logic                   line_we;
    logic [LINE_BITS-1:0]   line_wdata;

    logic [OFF_W-1:0]       off;
    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag;
    logic                   lookup_hit, mem_done, last;
    logic [LINE_BITS-1:0]   cur_line;

    assign off        = addr_q[OFF_W-1:0];
    assign idx        = addr_q[OFF_W +: IDX_W];
    assign tag        = addr_q[ADDR_W-1 -: TAG_W];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
    assign cur_line   = line_mem[idx];
    assign mem_done   = mreq_q && mem_ready;
    assign last       = (cnt_q == IDX_W'(NUM_LINES - 1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        first_d    = first_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        fdone_d    = 1'b0;
        mreq_d     = mreq_q;
        mwe_d      = mwe_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        line_we    = 1'b0;
        line_wdata = cur_line;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    cnt_d   = '0;
                    state_d = FLUSH_SCAN;
                end else if (cpu_req && !ack_q) begin
                    // the ack cycle is still IDLE, so a held request must not re-enter here
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    first_d = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                first_d = 1'b0;
                if (lookup_hit) begin
                    hit_d = first_q;
                    if (we_q) begin
                        line_we = 1'b1;
                        line_wdata[{off, 3'b000} +: 8] = wdata_q;
                        dirty_d[idx] = 1'b1;
                    end else begin
                        rdata_d = cur_line[{off, 3'b000} +: 8];
                    end
                    state_d = RESPOND;
                end else begin
                    miss_d = first_q;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        mreq_d   = 1'b1;
                        mwe_d    = 1'b1;
                        maddr_d  = {tag_q[idx], idx, {OFF_W{1'b0}}};
                        mwdata_d = cur_line;
                        state_d  = WRITEBACK;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_done) begin
                    mreq_d  = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (!mreq_q) begin
                    mreq_d  = 1'b1;
                    mwe_d   = 1'b0;
                    maddr_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                end else if (mem_ready) begin
                    mreq_d       = 1'b0;
                    line_we      = 1'b1;
                    line_wdata   = mem_rdata;
                    tag_d[idx]   = tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = LOOKUP;
                end
            end
            RESPOND: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            FLUSH_SCAN: begin
                if (valid_q[cnt_q] && dirty_q[cnt_q]) begin
                    mreq_d   = 1'b1;
                    mwe_d    = 1'b1;
                    maddr_d  = {tag_q[cnt_q], cnt_q, {OFF_W{1'b0}}};
                    mwdata_d = line_mem[cnt_q];
                    state_d  = FLUSH_WB;
                end else begin
                    valid_d[cnt_q] = 1'b0;
                    if (last) begin
                        fdone_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            FLUSH_WB: begin
                if (mem_done) begin
                    mreq_d         = 1'b0;
                    valid_d[cnt_q] = 1'b0;
                    dirty_d[cnt_q] = 1'b0;
                    if (last) begin
                        fdone_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + IDX_W'(1);
                        state_d = FLUSH_SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            first_q  <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            tag_q    <= '{default: '0};
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            fdone_q  <= 1'b0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            first_q  <= first_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            tag_q    <= tag_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            fdone_q  <= fdone_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    // line storage carries no reset so it can map onto plain RAM
    always_ff @(posedge clk) begin
        if (line_we) begin
            line_mem[idx] <= line_wdata;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_ack    = ack_q;
    assign busy       = (state_q != IDLE);
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign flush_done = fdone_q;
    assign mem_req    = mreq_q;
    assign mem_we     = mwe_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = mwdata_q;
endmodule
